// File: rtl/dm_responder.sv
// Data-memory responder: single-outstanding load/store with fixed response latency.
// Define DM_TRACE_EN to print a trace line for every successful store.
module dm_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           rd_word, rd_shift, load_data, merged, lane_mask, lane_data;
    logic [15:0]           lane_h;
    logic [7:0]            lane_b;
    logic                  acc_err, mem_we;

    assign word_idx = addr_q[ADDR_WIDTH+1:2];
    assign rd_word  = mem[word_idx];

    always_comb begin
        acc_err = 1'b0;
        if (ctrl_q > 3'd4)
            acc_err = 1'b1;
        if ((ctrl_q == 3'd1 || ctrl_q == 3'd2) && addr_q[0])
            acc_err = 1'b1;
        if (ctrl_q == 3'd0 && addr_q[1:0] != 2'b00)
            acc_err = 1'b1;
        if (addr_q[31:ADDR_WIDTH+2] != '0)
            acc_err = 1'b1;
    end

    always_comb begin
        rd_shift = rd_word >> {addr_q[1:0], 3'b000};
        lane_b   = rd_shift[7:0];
        lane_h   = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (ctrl_q)
            3'd0:    load_data = rd_word;
            3'd1:    load_data = {16'h0000, lane_h};
            3'd2:    load_data = {{16{lane_h[15]}}, lane_h};
            3'd3:    load_data = {24'h000000, lane_b};
            3'd4:    load_data = {{24{lane_b[7]}}, lane_b};
            default: load_data = '0;
        endcase
    end

    // Signed store types share the unsigned lane masks; only the width matters.
    always_comb begin
        case (ctrl_q)
            3'd1, 3'd2: begin
                lane_mask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                lane_data = {2{wdata_q[15:0]}};
            end
            3'd3, 3'd4: begin
                lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
                lane_data = {4{wdata_q[7:0]}};
            end
            default: begin
                lane_mask = '1;
                lane_data = wdata_q;
            end
        endcase
        merged = (rd_word & ~lane_mask) | (lane_data & lane_mask);
    end

    assign mem_we = (state_q == BUSY) && (cnt_q == '0) && we_q && !acc_err;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        ctrl_d       = ctrl_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    ctrl_d      = req_ctrl;
                    wdata_d     = req_wdata;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = acc_err;
                    resp_rdata_d = (acc_err || we_q) ? '0 : load_data;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            ctrl_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            ctrl_q       <= ctrl_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[word_idx] <= merged;
    end

`ifdef DM_TRACE_EN
    logic [31:0] pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc_q <= '0;
        else if (state_q == IDLE && req_valid)
            pc_q <= req_pc;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            $display("@%08h: *%08h <= %08h", pc_q, {addr_q[31:2], 2'b00}, merged);
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (ADDR_WIDTH=12, LATENCY=2).
module tb_dm_responder;
    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_ctrl;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int unsigned n_tests;
    int unsigned n_fail;

    dm_responder #(.ADDR_WIDTH(12), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_ctrl   (req_ctrl),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One transaction; checks latency, response fields, and completes the handshake if resp_ready=1.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [2:0] ctrl, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int unsigned n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_ctrl  = ctrl;
        req_wdata = wdata;
        req_pc    = 32'h0000_1000 + addr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".lat"}, n, 32'd2);
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        check({tag, ".err"}, {31'b0, resp_err}, {31'b0, exp_err});
        if (resp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_ctrl   = '0;
        req_wdata  = '0;
        req_pc     = '0;
        resp_ready = 1'b1;
        #12;
        check("rst.req_ready", {31'b0, req_ready}, 32'd1);
        check("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_err", {31'b0, resp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        access("st_w10",  1'b1, 32'h10, 3'd0, 32'h1234_5678, 32'h0, 1'b0);
        access("ld_w10",  1'b0, 32'h10, 3'd0, 32'h0,         32'h1234_5678, 1'b0);
        access("st_b13",  1'b1, 32'h13, 3'd3, 32'hFFFF_FFAB, 32'h0, 1'b0);
        access("ld_bs13", 1'b0, 32'h13, 3'd4, 32'h0,         32'hFFFF_FFAB, 1'b0);
        access("ld_bu13", 1'b0, 32'h13, 3'd3, 32'h0,         32'h0000_00AB, 1'b0);
        access("ld_w10b", 1'b0, 32'h10, 3'd0, 32'h0,         32'hAB34_5678, 1'b0);
        access("st_h12",  1'b1, 32'h12, 3'd2, 32'hDEAD_8001, 32'h0, 1'b0);
        access("ld_hs12", 1'b0, 32'h12, 3'd2, 32'h0,         32'hFFFF_8001, 1'b0);
        access("ld_hu12", 1'b0, 32'h12, 3'd1, 32'h0,         32'h0000_8001, 1'b0);
        access("ld_w10c", 1'b0, 32'h10, 3'd0, 32'h0,         32'h8001_5678, 1'b0);
        access("ld_bu10", 1'b0, 32'h10, 3'd3, 32'h0,         32'h0000_0078, 1'b0);
        access("ld_hs10", 1'b0, 32'h10, 3'd2, 32'h0,         32'h0000_5678, 1'b0);

        access("err_wmis", 1'b1, 32'h11,      3'd0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        access("err_hmis", 1'b0, 32'h13,      3'd2, 32'h0,         32'h0, 1'b1);
        access("err_ctrl", 1'b0, 32'h10,      3'd6, 32'h0,         32'h0, 1'b1);
        access("err_oor",  1'b1, 32'h1_0000,  3'd0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        access("err_oor2", 1'b0, 32'h4000,    3'd0, 32'h0,         32'h0, 1'b1);
        access("st_top",   1'b1, 32'h3FFC,    3'd0, 32'h5A5A_A5A5, 32'h0, 1'b0);
        access("ld_top",   1'b0, 32'h3FFC,    3'd0, 32'h0,         32'h5A5A_A5A5, 1'b0);
        access("ld_w10d",  1'b0, 32'h10,      3'd0, 32'h0,         32'h8001_5678, 1'b0);
        access("st_w20",   1'b1, 32'h20,      3'd0, 32'hCAFE_F00D, 32'h0, 1'b0);

        // Backpressure: response held, stray request ignored.
        resp_ready = 1'b0;
        access("bp_ld", 1'b0, 32'h10, 3'd0, 32'h0, 32'h8001_5678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h20;
            req_ctrl  = 3'd0;
            req_wdata = 32'hBAD0_BAD0;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            check("bp.resp_valid", {31'b0, resp_valid}, 32'd1);
            check("bp.resp_rdata", resp_rdata, 32'h8001_5678);
            check("bp.req_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rel.resp_valid", {31'b0, resp_valid}, 32'd0);
        check("bp_rel.resp_rdata", resp_rdata, 32'd0);
        check("bp_rel.req_ready", {31'b0, req_ready}, 32'd1);
        access("ld_w20", 1'b0, 32'h20, 3'd0, 32'h0, 32'hCAFE_F00D, 1'b0);

        // Asynchronous reset while a store is pending in BUSY.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_ctrl  = 3'd0;
        req_wdata = 32'h1111_1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("mid.req_ready", {31'b0, req_ready}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("arst.req_ready", {31'b0, req_ready}, 32'd1);
        check("arst.resp_valid", {31'b0, resp_valid}, 32'd0);
        check("arst.resp_err", {31'b0, resp_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        access("ld_w20b", 1'b0, 32'h20, 3'd0, 32'h0, 32'hCAFE_F00D, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
